// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared types and sizes for the execute stage.
//   XLEN        : datapath width, from `INSTRUCTION_WIDTH
//   REG_ADDR_W  : register address width, from `NUM_REGS_BIT_COUNT
//   alu_op_e    : 4-bit operation code; codes above ALU_MUL are undefined
//   exec_state_e: execute unit control states
// ---------------------------------------------------------------------------
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef NUM_REGS_BIT_COUNT
`define NUM_REGS_BIT_COUNT 5
`endif

package core_pkg;

    localparam int XLEN        = `INSTRUCTION_WIDTH;
    localparam int REG_ADDR_W  = `NUM_REGS_BIT_COUNT;
    localparam int SHAMT_W     = $clog2(XLEN);
    localparam int MUL_COUNT_W = $clog2(XLEN);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } exec_state_e;

    // The multiply is the only operation that leaves the single-cycle path.
    function automatic logic isMulOp(input alu_op_e op);
        return op == ALU_MUL;
    endfunction

endpackage

// File: rtl/execute_unit_if.sv
// ---------------------------------------------------------------------------
// execute_unit_if
// Request and register-file write bundle of the execute unit.
//   Request side : in_valid, in_ready, in_op, in_rs1_data, in_rs2_data,
//                  in_rd_addr, flush
//   Status       : busy
//   Write port   : rd_write_en, rd_addr, rd_data
// master = issuing stage, slave = execute unit.
// ---------------------------------------------------------------------------
interface execute_unit_if;
    import core_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    alu_op_e               in_op;
    logic [XLEN-1:0]       in_rs1_data;
    logic [XLEN-1:0]       in_rs2_data;
    logic [REG_ADDR_W-1:0] in_rd_addr;
    logic                  flush;
    logic                  busy;
    logic                  rd_write_en;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd_data;

    modport master (
        output in_valid, in_op, in_rs1_data, in_rs2_data, in_rd_addr, flush,
        input  in_ready, busy, rd_write_en, rd_addr, rd_data
    );

    modport slave (
        input  in_valid, in_op, in_rs1_data, in_rs2_data, in_rd_addr, flush,
        output in_ready, busy, rd_write_en, rd_addr, rd_data
    );

endinterface

// File: rtl/iterative_multiplier.sv
// ---------------------------------------------------------------------------
// iterative_multiplier
// Shift-add multiplier, one partial product per cycle, XLEN iterations.
//   clk, rst_n      : clock, async active-low reset
//   start_i         : load operands (one-cycle pulse)
//   flush_i         : abandon the current product
//   multiplicand_i  : operand A, sampled on start
//   multiplier_i    : operand B, sampled on start
//   done_o          : high during the final iteration cycle
//   product_o       : low XLEN bits of A*B, valid while done_o is high
// ---------------------------------------------------------------------------
module iterative_multiplier
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] multiplicand_i,
    input  logic [XLEN-1:0] multiplier_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam logic [MUL_COUNT_W-1:0] LAST_STEP = MUL_COUNT_W'(XLEN - 1);

    logic                   active_q;
    logic [MUL_COUNT_W-1:0] count_q;
    logic [XLEN-1:0]        acc_q;
    logic [XLEN-1:0]        mcand_q;
    logic [XLEN-1:0]        mplier_q;
    logic [XLEN-1:0]        accSum_d;

    // Partial-product accumulate for the current iteration. The product is
    // taken from this sum rather than acc_q so the result is available in the
    // last iteration cycle itself, giving exactly XLEN cycles of latency.
    always_comb begin
        accSum_d = acc_q;
        if (mplier_q[0]) begin
            accSum_d = acc_q + mcand_q;
        end
    end

    assign done_o    = active_q && (count_q == LAST_STEP);
    assign product_o = accSum_d;

    // Iteration registers: the multiplicand walks left, the multiplier walks
    // right, and bits shifted past XLEN are dropped since only the low half
    // of the product is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (flush_i) begin
            active_q <= 1'b0;
            count_q  <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= multiplicand_i;
            mplier_q <= multiplier_i;
        end else if (active_q) begin
            acc_q    <= accSum_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (count_q == LAST_STEP) begin
                active_q <= 1'b0;
                count_q  <= '0;
            end else begin
                count_q  <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/execute_unit.sv
// ---------------------------------------------------------------------------
// execute_unit
// Integer execute stage: single-cycle ALU ops and an iterative multiply,
// writing one result per accepted request to the register-file write port.
//   clk, rst_n : clock, async active-low reset
//   bus        : execute_unit_if.slave
//                request  in_valid/in_ready, in_op, in_rs1_data,
//                         in_rs2_data, in_rd_addr, flush
//                status   busy (multiply in flight)
//                write    rd_write_en strobe, rd_addr, rd_data
// ---------------------------------------------------------------------------
module execute_unit
    import core_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    execute_unit_if.slave bus
);

    exec_state_e           state_q, state_d;
    logic                  wrEn_q, wrEn_d;
    logic [REG_ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [XLEN-1:0]       wrData_q, wrData_d;
    logic [REG_ADDR_W-1:0] mulAddr_q, mulAddr_d;
    logic                  accept;
    logic                  mulStart;
    logic                  mulDone;
    logic [XLEN-1:0]       mulProduct;
    logic [XLEN-1:0]       aluResult;
    logic [SHAMT_W-1:0]    shamt;

    iterative_multiplier u_mul (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (mulStart),
        .flush_i        (bus.flush),
        .multiplicand_i (bus.in_rs1_data),
        .multiplier_i   (bus.in_rs2_data),
        .done_o         (mulDone),
        .product_o      (mulProduct)
    );

    assign shamt  = bus.in_rs2_data[SHAMT_W-1:0];
    assign accept = bus.in_valid && (state_q == ST_IDLE) && !bus.flush;

    // Single-cycle result straight from the request operands; undefined
    // codes (and MUL, which never uses this path) produce zero.
    always_comb begin
        aluResult = '0;
        case (bus.in_op)
            ALU_ADD:  aluResult = bus.in_rs1_data + bus.in_rs2_data;
            ALU_SUB:  aluResult = bus.in_rs1_data - bus.in_rs2_data;
            ALU_AND:  aluResult = bus.in_rs1_data & bus.in_rs2_data;
            ALU_OR:   aluResult = bus.in_rs1_data | bus.in_rs2_data;
            ALU_XOR:  aluResult = bus.in_rs1_data ^ bus.in_rs2_data;
            ALU_SLL:  aluResult = bus.in_rs1_data << shamt;
            ALU_SRL:  aluResult = bus.in_rs1_data >> shamt;
            ALU_SRA:  aluResult = $signed(bus.in_rs1_data) >>> shamt;
            ALU_SLT:  aluResult = {{(XLEN-1){1'b0}},
                                   $signed(bus.in_rs1_data) < $signed(bus.in_rs2_data)};
            ALU_SLTU: aluResult = {{(XLEN-1){1'b0}},
                                   bus.in_rs1_data < bus.in_rs2_data};
            default:  aluResult = '0;
        endcase
    end

    // Control: flush wins over everything and also suppresses the multiply
    // write if it lands in the final iteration cycle. Write address/data only
    // change when a strobe is produced, so they hold between writes.
    always_comb begin
        state_d   = state_q;
        wrEn_d    = 1'b0;
        wrAddr_d  = wrAddr_q;
        wrData_d  = wrData_q;
        mulAddr_d = mulAddr_q;
        mulStart  = 1'b0;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (isMulOp(bus.in_op)) begin
                            state_d   = ST_MUL_BUSY;
                            mulStart  = 1'b1;
                            mulAddr_d = bus.in_rd_addr;
                        end else begin
                            wrEn_d   = 1'b1;
                            wrAddr_d = bus.in_rd_addr;
                            wrData_d = aluResult;
                        end
                    end
                end
                ST_MUL_BUSY: begin
                    if (mulDone) begin
                        state_d  = ST_IDLE;
                        wrEn_d   = 1'b1;
                        wrAddr_d = mulAddr_q;
                        wrData_d = mulProduct;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and write-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wrEn_q    <= 1'b0;
            wrAddr_q  <= '0;
            wrData_q  <= '0;
            mulAddr_q <= '0;
        end else begin
            state_q   <= state_d;
            wrEn_q    <= wrEn_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
            mulAddr_q <= mulAddr_d;
        end
    end

    assign bus.in_ready    = (state_q == ST_IDLE);
    assign bus.busy        = (state_q == ST_MUL_BUSY);
    assign bus.rd_write_en = wrEn_q;
    assign bus.rd_addr     = wrAddr_q;
    assign bus.rd_data     = wrData_q;

endmodule

// File: tb/tb_execute_unit.sv
// ---------------------------------------------------------------------------
// tb_execute_unit
// Self-checking bench for execute_unit with a behavioural result model.
// ---------------------------------------------------------------------------
module tb_execute_unit;
    import core_pkg::*;

    localparam int W = XLEN;
    localparam int A = REG_ADDR_W;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    execute_unit_if bus ();

    execute_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stop a hung run with a failure line rather than spinning forever.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    // Architectural result of one operation, computed from the operation
    // definitions with plain arithmetic.
    function automatic logic [W-1:0] refModel(input alu_op_e op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        int unsigned       sh;
        longint            sa;
        longint            sb;
        logic [2*W-1:0]    p;
        sh = b % W;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return W'(sa >>> sh);
            ALU_SLT:  return (sa < sb) ? W'(1) : W'(0);
            ALU_SLTU: return (a < b) ? W'(1) : W'(0);
            ALU_MUL: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                return p[W-1:0];
            end
            default:  return '0;
        endcase
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input alu_op_e op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [A-1:0] rd);
        bus.in_valid    = 1'b1;
        bus.in_op       = op;
        bus.in_rs1_data = a;
        bus.in_rs2_data = b;
        bus.in_rd_addr  = rd;
    endtask

    task automatic idleInputs();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    function automatic logic [W-1:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.flush       = 1'b0;
        bus.in_op       = ALU_ADD;
        bus.in_rs1_data = '0;
        bus.in_rs2_data = '0;
        bus.in_rd_addr  = '0;
        #12;
        vectors++;
        if ({bus.busy, bus.rd_write_en} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: busy/wen=%b expected 00", {bus.busy, bus.rd_write_en});
        end
        vectors++;
        if (bus.rd_addr !== '0 || bus.rd_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_write_port: addr=%h data=%h expected 0/0", bus.rd_addr, bus.rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: in_ready=%b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        applyStimulus(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 5'd5);
        tick();
        idleInputs();
        vectors++;
        if ({bus.rd_write_en, bus.rd_addr, bus.rd_data} !== {1'b1, 5'd5, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL add_wrap: wen=%b addr=%0d data=%h expected 1/5/00000000",
                     bus.rd_write_en, bus.rd_addr, bus.rd_data);
        end
        applyStimulus(ALU_SRA, 32'h8000_0000, 32'h21, 5'd3);
        tick();
        idleInputs();
        vectors++;
        if ({bus.rd_write_en, bus.rd_data} !== {1'b1, 32'hC000_0000}) begin
            miscompares++;
            $display("[TB] FAIL sra_shamt: wen=%b data=%h expected 1/c0000000", bus.rd_write_en, bus.rd_data);
        end
        tick();
        vectors++;
        if ({bus.rd_write_en, bus.rd_addr, bus.rd_data} !== {1'b0, 5'd3, 32'hC000_0000}) begin
            miscompares++;
            $display("[TB] FAIL hold_when_idle: wen=%b addr=%0d data=%h expected 0/3/c0000000",
                     bus.rd_write_en, bus.rd_addr, bus.rd_data);
        end
        applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'h0, 5'd7);
        tick();
        vectors++;
        if ({bus.rd_write_en, bus.rd_data} !== {1'b1, 32'h1}) begin
            miscompares++;
            $display("[TB] FAIL slt_signed: wen=%b data=%h expected 1/00000001", bus.rd_write_en, bus.rd_data);
        end
        applyStimulus(ALU_SLTU, 32'hFFFF_FFFF, 32'h0, 5'd8);
        tick();
        idleInputs();
        vectors++;
        if ({bus.rd_write_en, bus.rd_addr, bus.rd_data} !== {1'b1, 5'd8, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL sltu_unsigned: wen=%b addr=%0d data=%h expected 1/8/00000000",
                     bus.rd_write_en, bus.rd_addr, bus.rd_data);
        end
        tick();
    endtask

    task automatic test_random_alu();
        alu_op_e        op;
        logic [W-1:0]   a, b, exp;
        logic [A-1:0]   rd;
        int             code;
        for (int i = 0; i < 80; i++) begin
            code = $urandom_range(0, 15);
            if (code == 10) code = 12;
            op  = alu_op_e'(4'(code));
            a   = randOperand();
            b   = randOperand();
            rd  = A'($urandom);
            exp = refModel(op, a, b);
            applyStimulus(op, a, b, rd);
            tick();
            vectors++;
            if ({bus.rd_write_en, bus.rd_addr, bus.rd_data} !== {1'b1, rd, exp}) begin
                miscompares++;
                $display("[TB] FAIL alu_op%0d: wen=%b addr=%0d data=%h expected 1/%0d/%h (a=%h b=%h)",
                         code, bus.rd_write_en, bus.rd_addr, bus.rd_data, rd, exp, a, b);
            end
            if ($urandom_range(0, 1) == 1) begin
                idleInputs();
                tick();
                vectors++;
                if (bus.rd_write_en !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL alu_idle_strobe: wen=%b expected 0", bus.rd_write_en);
                end
            end
        end
        idleInputs();
        tick();
    endtask

    task automatic test_back_to_back();
        alu_op_e      ops[3];
        logic [W-1:0] as[3], bs[3];
        logic [A-1:0] rds[3];
        ops = '{ALU_ADD, ALU_XOR, ALU_OR};
        for (int i = 0; i < 3; i++) begin
            as[i]  = W'($urandom);
            bs[i]  = W'($urandom);
            rds[i] = A'(i * 7 + 1);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(ops[i], as[i], bs[i], rds[i]);
            tick();
            vectors++;
            if ({bus.rd_write_en, bus.rd_addr, bus.rd_data} !== {1'b1, rds[i], refModel(ops[i], as[i], bs[i])}) begin
                miscompares++;
                $display("[TB] FAIL b2b_write%0d: wen=%b addr=%0d data=%h expected 1/%0d/%h",
                         i, bus.rd_write_en, bus.rd_addr, bus.rd_data, rds[i], refModel(ops[i], as[i], bs[i]));
            end
        end
        idleInputs();
        tick();
        vectors++;
        if (bus.rd_write_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_tail: wen=%b expected 0", bus.rd_write_en);
        end
    endtask

    task automatic test_mul_stall();
        logic [W-1:0] addA, addB;
        int           bad;
        addA = W'($urandom);
        addB = W'($urandom);
        applyStimulus(ALU_MUL, 32'h0001_0001, 32'h0001_0001, 5'd7);
        tick();
        applyStimulus(ALU_ADD, addA, addB, 5'd9);
        bad = 0;
        for (int k = 1; k <= W; k++) begin
            if ({bus.in_ready, bus.busy, bus.rd_write_en} !== 3'b010) begin
                if (bad == 0)
                    $display("[TB] FAIL mul_stall_cycle%0d: ready/busy/wen=%b expected 010",
                             k, {bus.in_ready, bus.busy, bus.rd_write_en});
                bad++;
            end
            tick();
        end
        vectors++;
        if (bad != 0) miscompares++;
        vectors++;
        if ({bus.rd_write_en, bus.rd_addr, bus.rd_data, bus.in_ready, bus.busy} !==
            {1'b1, 5'd7, 32'h0002_0001, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL mul_result: wen=%b addr=%0d data=%h ready=%b busy=%b expected 1/7/00020001/1/0",
                     bus.rd_write_en, bus.rd_addr, bus.rd_data, bus.in_ready, bus.busy);
        end
        tick();
        idleInputs();
        vectors++;
        if ({bus.rd_write_en, bus.rd_addr, bus.rd_data} !== {1'b1, 5'd9, refModel(ALU_ADD, addA, addB)}) begin
            miscompares++;
            $display("[TB] FAIL add_after_mul: wen=%b addr=%0d data=%h expected 1/9/%h",
                     bus.rd_write_en, bus.rd_addr, bus.rd_data, refModel(ALU_ADD, addA, addB));
        end
        tick();
    endtask

    task automatic test_random_mul();
        logic [W-1:0] a, b;
        logic [A-1:0] rd;
        int           lat;
        for (int i = 0; i < 5; i++) begin
            a  = randOperand();
            b  = randOperand();
            rd = A'($urandom);
            applyStimulus(ALU_MUL, a, b, rd);
            tick();
            idleInputs();
            lat = 1;
            while (bus.rd_write_en !== 1'b1 && lat < W + 6) begin
                tick();
                lat++;
            end
            vectors++;
            if (lat != W + 1) begin
                miscompares++;
                $display("[TB] FAIL mul_latency%0d: latency=%0d expected %0d", i, lat, W + 1);
            end
            vectors++;
            if ({bus.rd_addr, bus.rd_data} !== {rd, refModel(ALU_MUL, a, b)}) begin
                miscompares++;
                $display("[TB] FAIL mul_value%0d: addr=%0d data=%h expected %0d/%h (a=%h b=%h)",
                         i, bus.rd_addr, bus.rd_data, rd, refModel(ALU_MUL, a, b), a, b);
            end
            tick();
        end
    endtask

    task automatic test_flush_mul();
        logic [W-1:0] a, b;
        int           stray;
        a = W'($urandom) | 1;
        b = W'($urandom) | 1;
        applyStimulus(ALU_MUL, a, b, 5'd11);
        tick();
        idleInputs();
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        vectors++;
        if ({bus.in_ready, bus.busy, bus.rd_write_en} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL flush_state: ready/busy/wen=%b expected 100",
                     {bus.in_ready, bus.busy, bus.rd_write_en});
        end
        stray = 0;
        for (int k = 0; k < 2 * W; k++) begin
            tick();
            if (bus.rd_write_en !== 1'b0) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("[TB] FAIL flush_no_write: strobes=%0d expected 0", stray);
        end
        applyStimulus(ALU_ADD, 32'h5, 32'h6, 5'd12);
        bus.flush = 1'b1;
        tick();
        idleInputs();
        vectors++;
        if (bus.rd_write_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_blocks_accept: wen=%b expected 0", bus.rd_write_en);
        end
        tick();
        vectors++;
        if (bus.rd_write_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_late_write: wen=%b expected 0", bus.rd_write_en);
        end
    endtask

    task automatic test_reset_mid_mul();
        int stray;
        applyStimulus(ALU_ADD, 32'h1234_5679, 32'h0, 5'd13);
        tick();
        applyStimulus(ALU_MUL, W'($urandom) | 1, W'($urandom) | 1, 5'd14);
        tick();
        idleInputs();
        repeat (5) tick();
        vectors++;
        if ({bus.busy, bus.rd_addr, bus.rd_data} !== {1'b1, 5'd13, 32'h1234_5679}) begin
            miscompares++;
            $display("[TB] FAIL pre_reset: busy=%b addr=%0d data=%h expected 1/13/12345679",
                     bus.busy, bus.rd_addr, bus.rd_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.busy, bus.rd_write_en, bus.rd_addr, bus.rd_data} !== {3'b100, 5'd0, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL async_reset: ready/busy/wen=%b addr=%0d data=%h expected 100/0/00000000",
                     {bus.in_ready, bus.busy, bus.rd_write_en}, bus.rd_addr, bus.rd_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 2 * W + 4; k++) begin
            tick();
            if (bus.rd_write_en !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_abandon: bad_cycles=%0d expected 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_alu();
        test_back_to_back();
        test_mul_stall();
        test_random_mul();
        test_flush_mul();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 Parameter: none; widths SHALL come from the global defines `INSTRUCTION_WIDTH (W) and `NUM_REGS_BIT_COUNT (A).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 in_op  input  4  operation code of type alu_op_e.
REQ-007 in_rs1_data  input  W  operand A, taken from register-file read port 1.
REQ-008 in_rs2_data  input  W  operand B, taken from register-file read port 2.
REQ-009 in_rd_addr  input  A  destination register address.
REQ-010 flush  input  1  synchronous abort of any in-flight operation.
REQ-011 busy  output  1  multi-cycle operation in flight.
REQ-012 rd_write_en  output  1  one-cycle write strobe to the register-file write port.
REQ-013 rd_addr  output  A  write address; valid when rd_write_en=1.
REQ-014 rd_data  output  W  write data; valid when rd_write_en=1.

Function
REQ-015 Accept SHALL occur in a cycle where in_valid=1, in_ready=1 and flush=0; operands, op and rd_addr SHALL be captured on that edge.
REQ-016 States: IDLE, MUL_BUSY; in_ready=1 only in IDLE; busy=1 only in MUL_BUSY.
REQ-017 Single-cycle ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT (signed), SLTU; the result is registered, with rd_write_en=1 for exactly one cycle, the cycle after accept; the state stays IDLE, so back-to-back accepts SHALL give back-to-back writes.
REQ-018 Arithmetic SHALL wrap modulo 2^W; shift amount = rs2[$clog2(W)-1:0]; SLT and SLTU SHALL write 1 or 0, zero-extended.
REQ-019 MUL: on accept, IDLE->MUL_BUSY; one shift-add iteration per cycle for exactly W cycles; then MUL_BUSY->IDLE with rd_write_en=1 in the following cycle; accept at cycle N gives the write at cycle N+W+1; result = low W bits of the unsigned product.
REQ-020 The next request SHALL NOT be accepted until the MUL write cycle, in which in_ready=1 again.
REQ-021 Undefined opcode: accepted as single-cycle, rd_data=0, rd_write_en=1.
REQ-022 flush=1: state SHALL go to IDLE next edge, any pending or in-flight result SHALL be dropped, rd_write_en=0 next cycle, and no accept SHALL occur in the flush cycle.
REQ-023 rd_write_en SHALL be 0 in every cycle not named in REQ-017/019/021; rd_addr and rd_data SHALL hold their last value when the strobe is low.
REQ-024 There is no backpressure on the write port; the register file always accepts the write.

Reset
REQ-025 rst_n=0 SHALL immediately force: state=IDLE, in_ready=1 after release, busy=0, rd_write_en=0, rd_addr=0, rd_data=0, and all multiplier state zeroed.
REQ-026 Reset during MUL_BUSY SHALL abandon the operation with no write, including after reset release.

Structure
REQ-027 alu_op_e (4-bit enum) and the state enum SHALL live in shared package core_pkg.
REQ-028 The iterative multiplier SHALL be sub-module iterative_multiplier (start/done handshake, W-cycle latency); all other ops SHALL be implemented inline.

Verification
REQ-029 ADD rs1=0xFFFFFFFF, rs2=1, rd=5 at cycle N -> rd_write_en=1 at N+1, rd_addr=5, rd_data=0x00000000.
REQ-030 SRA rs1=0x80000000, rs2=0x21 -> rd_data=0xC0000000 (shift amount 1); SLT rs1=0xFFFFFFFF, rs2=0 -> 1; SLTU same operands -> 0.
REQ-031 MUL rs1=0x00010001, rs2=0x00010001 at N -> in_ready=0 for cycles N+1..N+W, write at N+33 (W=32) with rd_data=0x00020001; an ADD held valid during that time is accepted only at N+33.
REQ-032 Three back-to-back ADD/XOR/OR requests -> three consecutive write strobes, in order, with correct rd_addr.
REQ-033 MUL accepted, flush=1 at cycle 10 of the iteration -> no write at any later cycle, in_ready=1 on the next cycle.
REQ-034 rst_n low mid-MUL -> all outputs reach reset values asynchronously, and no write after release.
